exec_writeback: RTL
===================

EXEC_WRITEBACK -- requirements
Module: exec_writeback

Interface
REQ-001 Parameter: W, 16, operand/result width; all arithmetic rules below are stated for W=16.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-004 start  input  1  issue strobe, sampled on rising clk; qualifies op1/op2/funct.
REQ-005 op1  input  W  first operand, from register-file read port 1.
REQ-006 op2  input  W  second operand / shift amount, from register-file read port 2.
REQ-007 funct  input  4  operation select, from register-file decode.
REQ-008 Writedata  output  W  result to register-file write port.
REQ-009 RegWrite  output  1  register-file write enable, one-cycle pulse per completed write.
REQ-010 hi  output  W  upper product word (multiply) or remainder (divide); holds until next mul/div completes.
REQ-011 busy  output  1  high while an operation is in progress; start ignored while high.
REQ-012 ovf  output  1  signed overflow of last add/sub; valid with RegWrite.
REQ-013 divz  output  1  one-cycle pulse: divide by zero.
REQ-014 illegal  output  1  one-cycle pulse: unsupported funct.

Function
REQ-015 funct: 0000 add, 0001 sub (op1-op2), 0010 and, 0011 or, 0100 xor, 0101 mul unsigned, 0110 div unsigned, 1000 sll, 1001 srl, 1010 sra, 1011 rol, 1100 ror; all other codes illegal.
REQ-016 Shift/rotate amount = op2[3:0]; amount 0 returns op1 unchanged.
REQ-017 Add/sub wrap modulo 2^16; ovf = signed overflow; ovf=0 for all other ops.
REQ-018 States: IDLE, MUL, DIV, WB.
REQ-019 IDLE + start + single-cycle op -> WB; result registered; busy=1 for that cycle.
REQ-020 WB: RegWrite=1 and Writedata=result for exactly one cycle, then IDLE; start accepted in the WB cycle is ignored (busy=1).
REQ-021 IDLE + start + mul -> MUL: operands latched; 16 iterations of shift-add, one per cycle, then WB; Writedata=product[15:0], hi=product[31:16] updated in the WB cycle.
REQ-022 IDLE + start + div, op2!=0 -> DIV: 16 iterations of restoring division, one per cycle, then WB; Writedata=quotient, hi=remainder.
REQ-023 Latency, start edge to RegWrite high: single-cycle ops 1 cycle; mul/div 17 cycles.
REQ-024 Div with op2=0: no iteration; next cycle enters WB with Writedata=FFFF, hi=op1, divz pulsed in that WB cycle.
REQ-025 Illegal funct: stay IDLE, RegWrite stays 0, illegal pulsed next cycle, busy stays 0.
REQ-026 Operand/funct changes after acceptance do not affect the in-flight operation.
REQ-027 Writedata holds its last value when RegWrite=0.

Reset
REQ-028 reset=0: state IDLE; Writedata=0000, hi=0000, RegWrite=0, busy=0, ovf=0, divz=0, illegal=0; iteration counter 0.
REQ-029 reset asserted mid-mul/div aborts the operation; no RegWrite is produced for it after release.
REQ-030 First start is accepted on the first rising edge with reset=1.

Verification
REQ-031 add op1=7FFF op2=0001 -> one cycle later Writedata=8000, RegWrite=1 for one cycle, ovf=1.
REQ-032 mul op1=1234 op2=0010 -> busy 17 cycles; RegWrite at cycle 17, Writedata=2340, hi=0001.
REQ-033 div op1=0064 op2=0007 -> cycle 17 Writedata=000E, hi=0002; div op1=1234 op2=0000 -> cycle 1 Writedata=FFFF, hi=1234, divz=1.
REQ-034 ror op1=8001 op2=0001 -> Writedata=C000; sra op1=8000 op2=0004 -> F800; funct=1111 -> illegal=1, RegWrite never 1.
REQ-035 start mul, second start (add) at cycle 5 -> ignored; exactly one RegWrite, at cycle 17, with mul result.
REQ-036 start mul, reset low at cycle 8 -> all outputs 0 immediately; after release no RegWrite; new add then completes normally.

Source files
------------

// File: rtl/exec_writeback.sv
// Execute/writeback stage: single-cycle ALU ops plus iterative shift-add multiply
// and restoring divide, delivering one write-back pulse per completed operation.
module exec_writeback #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic [3:0]   funct,
  output logic [W-1:0] Writedata,
  output logic         RegWrite,
  output logic [W-1:0] hi,
  output logic         busy,
  output logic         ovf,
  output logic         divz,
  output logic         illegal
);

  localparam int CW = $clog2(W);

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0010;
  localparam logic [3:0] F_OR  = 4'b0011;
  localparam logic [3:0] F_XOR = 4'b0100;
  localparam logic [3:0] F_MUL = 4'b0101;
  localparam logic [3:0] F_DIV = 4'b0110;
  localparam logic [3:0] F_SLL = 4'b1000;
  localparam logic [3:0] F_SRL = 4'b1001;
  localparam logic [3:0] F_SRA = 4'b1010;
  localparam logic [3:0] F_ROL = 4'b1011;
  localparam logic [3:0] F_ROR = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    opnd;
  logic [W-1:0]    acc_hi, acc_lo;

  logic [CW-1:0]   amt;
  logic [W-1:0]    sum_w, diff_w;
  logic [W-1:0]    sc_result;
  logic            sc_ovf, sc_legal, is_mul, is_div;
  logic            last_iter;

  logic [W:0]      mul_sum;
  logic [W-1:0]    mul_hi_nx, mul_lo_nx;
  logic [W:0]      div_shift, div_diff;
  logic [W-1:0]    div_hi_nx, div_lo_nx;

  assign amt       = op2[CW-1:0];
  assign sum_w     = op1 + op2;
  assign diff_w    = op1 - op2;
  assign last_iter = (cnt == CW'(W - 1));

  assign RegWrite  = (state == WB);
  assign busy      = (state != IDLE);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_legal  = 1'b1;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    case (funct)
      F_ADD: begin
        sc_result = sum_w;
        sc_ovf    = (op1[W-1] == op2[W-1]) && (sum_w[W-1] != op1[W-1]);
      end
      F_SUB: begin
        sc_result = diff_w;
        sc_ovf    = (op1[W-1] != op2[W-1]) && (diff_w[W-1] != op1[W-1]);
      end
      F_AND: sc_result = op1 & op2;
      F_OR:  sc_result = op1 | op2;
      F_XOR: sc_result = op1 ^ op2;
      F_MUL: is_mul = 1'b1;
      F_DIV: is_div = 1'b1;
      F_SLL: sc_result = op1 << amt;
      F_SRL: sc_result = op1 >> amt;
      F_SRA: sc_result = $signed(op1) >>> amt;
      // Amount 0 shifts the complementary term by W, which yields 0 and leaves op1 intact.
      F_ROL: sc_result = (op1 << amt) | (op1 >> (W - int'(amt)));
      F_ROR: sc_result = (op1 >> amt) | (op1 << (W - int'(amt)));
      default: sc_legal = 1'b0;
    endcase
  end

  // One shift-add step: add multiplicand when the multiplier LSB is set, then shift the pair right.
  always_comb begin
    mul_sum                = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    {mul_hi_nx, mul_lo_nx} = {mul_sum, acc_lo[W-1:1]};
  end

  // One restoring step: shift in the next dividend bit, keep the trial difference if non-negative.
  always_comb begin
    div_shift = {acc_hi, acc_lo[W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (!div_diff[W]) begin
      div_hi_nx = div_diff[W-1:0];
      div_lo_nx = {acc_lo[W-2:0], 1'b1};
    end else begin
      div_hi_nx = div_shift[W-1:0];
      div_lo_nx = {acc_lo[W-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) begin
        if (is_mul)        state_nx = MUL;
        else if (is_div)   state_nx = (op2 == '0) ? WB : DIV;
        else if (sc_legal) state_nx = WB;
      end
      MUL, DIV: if (last_iter) state_nx = WB;
      WB:       state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Writedata <= '0;
      hi        <= '0;
      ovf       <= 1'b0;
      divz      <= 1'b0;
      illegal   <= 1'b0;
      cnt       <= '0;
      opnd      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
    end else begin
      divz    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (is_mul || (is_div && op2 != '0)) begin
            opnd   <= op2;
            acc_hi <= '0;
            acc_lo <= op1;
            cnt    <= '0;
          end else if (is_div) begin
            Writedata <= '1;
            hi        <= op1;
            ovf       <= 1'b0;
            divz      <= 1'b1;
          end else if (sc_legal) begin
            Writedata <= sc_result;
            ovf       <= sc_ovf;
          end else begin
            illegal <= 1'b1;
          end
        end
        MUL: begin
          acc_hi <= mul_hi_nx;
          acc_lo <= mul_lo_nx;
          cnt    <= last_iter ? '0 : cnt + 1'b1;
          if (last_iter) begin
            Writedata <= mul_lo_nx;
            hi        <= mul_hi_nx;
            ovf       <= 1'b0;
          end
        end
        DIV: begin
          acc_hi <= div_hi_nx;
          acc_lo <= div_lo_nx;
          cnt    <= last_iter ? '0 : cnt + 1'b1;
          if (last_iter) begin
            Writedata <= div_lo_nx;
            hi        <= div_hi_nx;
            ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
